fp_add_normalizer: RTL and testbench
====================================

Name: fp_add_normalizer

Overview:
- Post-add normalisation stage of the IEEE-754 single-precision adder path.
- Sits directly downstream of the 24-bit mantissa adder/subtractor. Consumes its 24-bit result and carry-out, plus the sign and aligned exponent carried alongside.
- Normalises iteratively: one right shift on carry-out, or one left shift per cycle until the hidden bit is set. Then packs a 32-bit IEEE word behind a valid/ready handshake.
- Rounding mode is round-toward-zero: shifted-out bits are discarded.

Parameters:
EXP_W, 8, exponent width
MANT_W, 24, mantissa width including hidden bit

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
in_valid  in  1  upstream operand valid
in_ready  out  1  stage can accept
in_sign  in  1  result sign from alignment stage
in_exp  in  EXP_W  common (larger) biased exponent
in_mant  in  MANT_W  adder/subtractor result
in_cout  in  1  adder carry-out
out_valid  out  1  packed result valid
out_ready  in  1  downstream accepts
out_result  out  1+EXP_W+MANT_W-1  {sign, exp, mant[22:0]}
out_zero  out  1  result is zero
out_ovf  out  1  exponent overflow, result is infinity
out_uflow  out  1  exponent underflow, flushed to zero

Behaviour:
- Clock and reset:
  - One clock, clk. Reset rst_n is asynchronous and active-low.
  - While rst_n=0: state IDLE, out_valid=0, out_result=0, all flags=0, internal mant/exp/sign=0.
- FSM states:
  - IDLE: in_ready=1.
  - NORM: in_ready=0.
  - DONE: in_ready=0.
  - in_ready is decoded from state, so it reads 1 during and after reset.
- Accept: occurs on an edge with state=IDLE and in_valid=1. Loading rules:
  - in_exp==0 or in_exp==255 (specials, handled upstream): register the operand unchanged, go straight to DONE, no flags.
  - in_cout=1 and in_exp==254: go to DONE with out_result={in_sign, 8'hFF, 23'h0} and out_ovf=1.
  - in_cout=1 otherwise: mant={1'b1, in_mant[23:1]}, exp=in_exp+1, go to NORM.
  - in_cout=0: mant=in_mant, exp=in_exp, go to NORM.
- NORM, evaluated once per cycle:
  - mant==0: sign forced to 0 (exact cancellation gives +0), exp=0, out_zero=1, go to DONE.
  - mant[23]==1: stay normalised, go to DONE.
  - mant[23]==0 and exp==1: flush to {sign, 0, 0}, out_uflow=1, go to DONE. No denormal output.
  - otherwise: mant<<=1, exp-=1, stay in NORM.
- DONE:
  - out_valid=1. out_result and flags are registered and held stable.
  - On an edge with out_ready=1: go to IDLE and drop out_valid.
  - No accept is possible in the same cycle, because in_ready=0 in DONE.
- Latency:
  - Accept edge k, zero left shifts needed: out_valid=1 after edge k+1.
  - Each required left shift adds one cycle; worst case 23 shifts.
  - Throughput: at most one operation per (latency+2) cycles.
- Width rules:
  - Exponent arithmetic is done at EXP_W+1 bits internally; overflow or underflow is detected before truncation.
  - Packing drops mant[23] (the hidden bit).
- Flags: mutually exclusive; valid only while out_valid=1; cleared on return to IDLE.
- Reset mid-operation: an asynchronous reset in NORM or DONE aborts immediately. The FSM returns to IDLE and the in-flight result is discarded.

Decomposition:
- Package fp_norm_pkg holds:
  - state enum (IDLE, NORM, DONE)
  - EXP_W=8, MANT_W=24
  - EXP_MAX=8'hFF, EXP_OVF_IN=8'hFE
  - result field offsets: SIGN_POS=31, EXP_LSB=23
- No sub-module. The shift/decrement datapath and the FSM stay in one module.

Test Plan:
- Already normalised: mant=24'h800000, exp=127, sign=0, cout=0 -> out_result=32'h3F800000, out_valid after edge k+1, no flags.
- Carry-out (1.0+1.0): mant=24'h000000, cout=1, exp=127 -> 32'h40000000 after edge k+1.
- Full left shift: mant=24'h000001, exp=127 -> 23 NORM shifts, exp=104, result 32'h34000000. out_valid after edge k+24, in_ready=0 throughout.
- Cancellation and overflow:
  - mant=0, sign=1, cout=0 -> 32'h00000000, out_zero=1.
  - exp=254, cout=1, sign=1 -> 32'hFF800000, out_ovf=1.
- Underflow: mant=24'h000010, exp=3 -> two shifts reach exp=1 with mant[23]=0 -> 32'h00000000, out_uflow=1.
- Handshake and reset:
  - Hold out_ready=0 for 5 cycles in DONE -> result and flags stable, in_valid ignored.
  - Assert rst_n=0 mid-NORM (during the 23-shift case) -> immediate IDLE, out_valid=0, in_ready=1.
  - Next operation after the reset completes correctly.

Source files
------------

// File: rtl/fp_norm_pkg.sv
// rtl/fp_norm_pkg.sv - shared types and constants for the fp adder normalisation stage
package fp_norm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int EXP_W  = 8;
  localparam int MANT_W = 24;

  localparam logic [EXP_W-1:0] EXP_MAX    = 8'hFF;
  localparam logic [EXP_W-1:0] EXP_OVF_IN = 8'hFE;

  localparam int SIGN_POS = 31;
  localparam int EXP_LSB  = 23;

endpackage

// File: rtl/fp_add_normalizer.sv
// rtl/fp_add_normalizer.sv - iterative post-add normaliser and IEEE-754 single packer
// Round-toward-zero: bits shifted out on carry-out are dropped, no denormal output.
module fp_add_normalizer #(
  parameter int EXP_W  = fp_norm_pkg::EXP_W,
  parameter int MANT_W = fp_norm_pkg::MANT_W
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        in_sign,
  input  logic [EXP_W-1:0]            in_exp,
  input  logic [MANT_W-1:0]           in_mant,
  input  logic                        in_cout,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [EXP_W+MANT_W-1:0]     out_result,
  output logic                        out_zero,
  output logic                        out_ovf,
  output logic                        out_uflow
);
  import fp_norm_pkg::*;

  localparam int RES_W = EXP_W + MANT_W;
  localparam logic [EXP_W:0] EXP_ONE = {{EXP_W{1'b0}}, 1'b1};

  state_t             state;
  logic [MANT_W-1:0]  mant;
  logic [EXP_W:0]     exp;
  logic               sign;
  logic [EXP_W:0]     exp_inc;
  logic [EXP_W:0]     exp_dec;

  // One extra exponent bit so increment/decrement never wrap silently.
  assign exp_inc  = {1'b0, in_exp} + EXP_ONE;
  assign exp_dec  = exp - EXP_ONE;
  assign in_ready = (state == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      mant       <= '0;
      exp        <= '0;
      sign       <= 1'b0;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_zero   <= 1'b0;
      out_ovf    <= 1'b0;
      out_uflow  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          out_valid <= 1'b0;
          out_zero  <= 1'b0;
          out_ovf   <= 1'b0;
          out_uflow <= 1'b0;
          if (in_valid) begin
            sign <= in_sign;
            if (in_exp == '0 || in_exp == EXP_MAX) begin
              // Zero/denormal/inf/NaN were already resolved upstream: pass through.
              mant       <= in_mant;
              exp        <= {1'b0, in_exp};
              out_result <= {in_sign, in_exp, in_mant[MANT_W-2:0]};
              out_valid  <= 1'b1;
              state      <= DONE;
            end else if (in_cout && in_exp == EXP_OVF_IN) begin
              mant       <= '0;
              exp        <= {1'b0, EXP_MAX};
              out_result <= {in_sign, EXP_MAX, {(MANT_W-1){1'b0}}};
              out_ovf    <= 1'b1;
              out_valid  <= 1'b1;
              state      <= DONE;
            end else if (in_cout) begin
              mant  <= {1'b1, in_mant[MANT_W-1:1]};
              exp   <= exp_inc;
              state <= NORM;
            end else begin
              mant  <= in_mant;
              exp   <= {1'b0, in_exp};
              state <= NORM;
            end
          end
        end

        NORM: begin
          if (mant == '0) begin
            sign       <= 1'b0;
            exp        <= '0;
            out_result <= '0;
            out_zero   <= 1'b1;
            out_valid  <= 1'b1;
            state      <= DONE;
          end else if (mant[MANT_W-1]) begin
            out_result <= {sign, exp[EXP_W-1:0], mant[MANT_W-2:0]};
            out_valid  <= 1'b1;
            state      <= DONE;
          end else if (exp == EXP_ONE) begin
            mant       <= '0;
            exp        <= '0;
            out_result <= {sign, {(RES_W-1){1'b0}}};
            out_uflow  <= 1'b1;
            out_valid  <= 1'b1;
            state      <= DONE;
          end else begin
            mant <= mant << 1;
            exp  <= exp_dec;
          end
        end

        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out_zero  <= 1'b0;
            out_ovf   <= 1'b0;
            out_uflow <= 1'b0;
            state     <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_add_normalizer.sv
// tb/tb_fp_add_normalizer.sv - directed table-driven bench for fp_add_normalizer
module tb_fp_add_normalizer;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [7:0]  in_exp;
  logic [23:0] in_mant;
  logic        in_cout;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_zero;
  logic        out_ovf;
  logic        out_uflow;

  int errors = 0;
  int checks = 0;

  fp_add_normalizer dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant), .in_cout(in_cout),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_zero(out_zero), .out_ovf(out_ovf), .out_uflow(out_uflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        sign;
    logic [7:0]  exp;
    logic [23:0] mant;
    logic        cout;
    logic [31:0] res;
    int          lat;
    logic        z;
    logic        o;
    logic        u;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endtask

  // Drive one operand and wait for out_valid; leaves the DUT in DONE.
  task automatic start_op(input vec_t v, output int lat, output logic busy_bad);
    @(negedge clk);
    in_valid = 1'b1;
    in_sign  = v.sign;
    in_exp   = v.exp;
    in_mant  = v.mant;
    in_cout  = v.cout;
    @(negedge clk);
    in_valid = 1'b0;
    lat      = 0;
    busy_bad = 1'b0;
    while (!out_valid && lat < 40) begin
      if (in_ready) busy_bad = 1'b1;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic release_op(input string nm);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({nm, " valid_drop"}, {31'd0, out_valid}, 32'd0);
    chk({nm, " ready_back"}, {31'd0, in_ready}, 32'd1);
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    int   lat;
    logic busy_bad;
    start_op(v, lat, busy_bad);
    chk({nm, " latency"}, lat, v.lat);
    chk({nm, " result"}, out_result, v.res);
    chk({nm, " flags"}, {29'd0, out_zero, out_ovf, out_uflow}, {29'd0, v.z, v.o, v.u});
    chk({nm, " busy"}, {31'd0, busy_bad}, 32'd0);
    chk({nm, " ready_done"}, {31'd0, in_ready}, 32'd0);
    release_op(nm);
  endtask

  initial begin
    int   lat;
    logic busy_bad;

    vecs[0]  = '{1'b0, 8'd127, 24'h800000, 1'b0, 32'h3F800000, 1,  1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 8'd127, 24'h000000, 1'b1, 32'h40000000, 1,  1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 8'd127, 24'h000001, 1'b0, 32'h34000000, 24, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 8'd127, 24'h000000, 1'b0, 32'h00000000, 1,  1'b1, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 8'd254, 24'h123456, 1'b1, 32'hFF800000, 0,  1'b0, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 8'd3,   24'h000010, 1'b0, 32'h00000000, 3,  1'b0, 1'b0, 1'b1};
    vecs[6]  = '{1'b0, 8'd255, 24'h400001, 1'b0, 32'h7FC00001, 0,  1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 8'd0,   24'h000005, 1'b0, 32'h80000005, 0,  1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 8'd130, 24'h800001, 1'b1, 32'h41C00000, 1,  1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 8'd100, 24'h400003, 1'b0, 32'hB1800006, 2,  1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 8'd253, 24'hFFFFFF, 1'b1, 32'h7F7FFFFF, 1,  1'b0, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 8'd1,   24'h800000, 1'b0, 32'h00800000, 1,  1'b0, 1'b0, 1'b0};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_sign   = 1'b0;
    in_exp    = '0;
    in_mant   = '0;
    in_cout   = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset ready", {31'd0, in_ready}, 32'd1);
    chk("reset valid", {31'd0, out_valid}, 32'd0);
    chk("reset result", out_result, 32'd0);
    chk("reset flags", {29'd0, out_zero, out_ovf, out_uflow}, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Backpressure: result and flags held, new operand ignored while in DONE.
    start_op(vecs[5], lat, busy_bad);
    in_valid = 1'b1;
    in_sign  = 1'b1;
    in_exp   = 8'd127;
    in_mant  = 24'h800000;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("hold%0d valid", c), {31'd0, out_valid}, 32'd1);
      chk($sformatf("hold%0d result", c), out_result, 32'h00000000);
      chk($sformatf("hold%0d uflow", c), {31'd0, out_uflow}, 32'd1);
    end
    in_valid = 1'b0;
    release_op("hold");

    // Asynchronous reset in the middle of the long shift sequence.
    @(negedge clk);
    in_valid = 1'b1;
    in_sign  = vecs[2].sign;
    in_exp   = vecs[2].exp;
    in_mant  = vecs[2].mant;
    in_cout  = vecs[2].cout;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    chk("midnorm ready", {31'd0, in_ready}, 32'd0);
    chk("midnorm valid", {31'd0, out_valid}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("abort ready", {31'd0, in_ready}, 32'd1);
    chk("abort valid", {31'd0, out_valid}, 32'd0);
    chk("abort result", out_result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    chk("after abort idle valid", {31'd0, out_valid}, 32'd0);
    run_vec(vecs[0], "post_reset");
    run_vec(vecs[9], "post_reset2");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
